// File: rtl/pc_branch_sequencer.sv
// pc_branch_sequencer: fetch/issue sequencer holding the program counter.
// Fetches one instruction word at a time, presents it downstream until
// accepted, then advances the PC by 4 or to a taken-branch target.
// Optional feature macro: PC_BRANCH_SEQUENCER_JUMP_EN adds J-type jumps
// (jump wins over a taken branch). Without it the jump ports are ignored.
module pc_branch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic [31:0] branch_imm,
    input  logic        jump_valid,
    input  logic [25:0] jump_index,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        ISSUE = 2'b10
    } state_t;

    // Low address bits of the reset vector are dropped so the PC is always word aligned.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_r;
    logic [31:0] instr_r;
    logic        imem_req_r;
    logic        instr_valid_r;

    logic [31:0] branch_off_s;
    logic [31:0] next_pc_s;

`ifdef PC_BRANCH_SEQUENCER_JUMP_EN
    // Upper offset bits shift out of the 32-bit word; they are deliberately dropped.
    logic        unused_s;
    assign unused_s = &{1'b0, branch_imm[31:30]};
`else
    // Jump ports exist but carry no function in this build.
    logic        unused_s;
    assign unused_s = &{1'b0, branch_imm[31:30], jump_valid, jump_index};
`endif

    // Next-PC selection used on acceptance: sequential, taken branch, or jump.
    always_comb begin
        branch_off_s = {branch_imm[29:0], 2'b00};
        next_pc_s    = pc_plus4_r;
`ifdef PC_BRANCH_SEQUENCER_JUMP_EN
        if (jump_valid) begin
            next_pc_s = {pc_plus4_r[31:28], jump_index, 2'b00};
        end else if (branch_valid && branch_taken) begin
            next_pc_s = pc_plus4_r + branch_off_s;
        end else begin
            next_pc_s = pc_plus4_r;
        end
`else
        if (branch_valid && branch_taken) begin
            next_pc_s = pc_plus4_r + branch_off_s;
        end else begin
            next_pc_s = pc_plus4_r;
        end
`endif
    end

    // Sequencer FSM with PC, latched instruction and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC_ALIGNED;
            pc_plus4_r    <= RESET_PC_ALIGNED + 32'd4;
            instr_r       <= 32'h0000_0000;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r    <= FETCH;
                    imem_req_r <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_r       <= imem_rdata;
                        state_r       <= ISSUE;
                        imem_req_r    <= 1'b0;
                        instr_valid_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc_r          <= next_pc_s;
                        pc_plus4_r    <= next_pc_s + 32'd4;
                        state_r       <= FETCH;
                        instr_valid_r <= 1'b0;
                        imem_req_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_r;
    assign instr_out   = instr_r;
    assign pc_out      = pc_r;
    assign pc_plus4    = pc_plus4_r;

endmodule

// File: doc/pc_branch_sequencer.md
PC_BRANCH_SEQUENCER -- requirements
Module: pc_branch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the word-aligned PC loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-004 The block SHALL have port imem_req, output, 1, the instruction-fetch request.
REQ-005 The block SHALL have port imem_addr, output, 32, the fetch address, equal to the current PC.
REQ-006 The block SHALL have port imem_ack, input, 1, the fetch-complete strobe, qualifying imem_rdata.
REQ-007 The block SHALL have port imem_rdata, input, 32, the fetched instruction word.
REQ-008 The block SHALL have port instr_valid, output, 1, meaning an instruction is presented downstream.
REQ-009 The block SHALL have port instr_out, output, 32, the latched instruction word.
REQ-010 The block SHALL have port stall, input, 1, meaning downstream refuses the presented instruction.
REQ-011 The block SHALL have port branch_valid, input, 1, meaning a branch resolution accompanies the accepted instruction.
REQ-012 The block SHALL have port branch_taken, input, 1, meaning the branch outcome.
REQ-013 The block SHALL have port branch_imm, input, 32, the sign-extended branch word offset.
REQ-014 The block SHALL have port jump_valid, input, 1, the jump request, used only under JUMP_EN.
REQ-015 The block SHALL have port jump_index, input, 26, the J-type target field.
REQ-016 The block SHALL have ports pc_out and pc_plus4, output, 32, carrying PC and PC+4.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH and ISSUE.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-019 In FETCH, imem_req SHALL be 1 with imem_addr=PC, held stable until imem_ack=1.
REQ-020 On imem_ack in FETCH, the block SHALL latch imem_rdata into instr_out and enter ISSUE on the next cycle.
REQ-021 In ISSUE, instr_valid SHALL be 1, and instr_out SHALL stay constant while stall=1.
REQ-022 An ISSUE cycle with stall=0 SHALL be an acceptance, updating PC on the next edge and returning to FETCH.
REQ-023 On acceptance, the next PC SHALL be pc_plus4 + (branch_imm<<2) if branch_valid&branch_taken, else pc_plus4.
REQ-024 Arithmetic SHALL be 32-bit modulo 2^32 with no overflow flag, so 32'hFFFF_FFFC+4 = 32'h0.
REQ-025 PC[1:0] SHALL always be 2'b00, and RESET_PC[1:0] SHALL be forced to 0.
REQ-026 branch_*, jump_* and stall SHALL be ignored outside ISSUE.
REQ-027 imem_ack outside FETCH SHALL be ignored.
REQ-028 imem_req and instr_valid SHALL never both be 1.
REQ-029 Acceptance-to-next-imem_req latency SHALL be one cycle, and ack-to-instr_valid latency SHALL be one cycle.

Reset
REQ-030 Reset SHALL win over every simultaneous event, including imem_ack or acceptance, in the same cycle.
REQ-031 On reset: state=IDLE, PC=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, pc_plus4=RESET_PC+4.
REQ-032 Reset mid-FETCH SHALL drop imem_req the next cycle and discard any pending fetch.

Configuration
REQ-033 With macro PC_BRANCH_SEQUENCER_JUMP_EN defined, an acceptance with jump_valid=1 SHALL load PC = {pc_plus4[31:28], jump_index, 2'b00}, with jump taking priority over a taken branch.
REQ-034 Without PC_BRANCH_SEQUENCER_JUMP_EN, jump_valid and jump_index SHALL be ignored, and the ports SHALL still exist.

Verification
REQ-035 Reset then release with RESET_PC=0 -> one IDLE cycle, then imem_req=1, imem_addr=0x0, pc_plus4=0x4.
REQ-036 PC=0x4, ack with 0x1234_5678, accept with branch taken, imm=0x2 -> instr_out=0x1234_5678, next imem_addr=0x10.
REQ-037 PC=0x10, accept with branch taken, imm=0xFFFF_FFFF -> next imem_addr=0x10; not taken -> next imem_addr=0x14.
REQ-038 PC=0xFFFF_FFFC, accept with no branch -> next imem_addr=0x0 (wrap).
REQ-039 In ISSUE hold stall=1 for 3 cycles with branch_valid=1 -> PC unchanged and instr_valid=1 throughout; PC advances only after stall falls.
REQ-040 Reset asserted in the same cycle as imem_ack -> instr_out=0, state IDLE, PC=RESET_PC; under JUMP_EN at PC=0x4 with jump_index=0x40 -> next imem_addr=0x100.
